// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter and the
// instruction register, and runs a two-state (IDLE/FETCH) handshake with
// instruction memory. A fetch that sees no ack within 16 cycles completes with a NOP
// and pulses fetch_err.
// Optional feature: define FETCH_HALT_DETECT_EN to latch a halt when a fetched
// word has opcode nibble 4'b1111. While halted, load_ir, inc_pc and load_pc are
// ignored until reset.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_ir,
    input  logic        inc_pc,
    input  logic        load_pc,
    input  logic        sel_pc,
    input  logic [7:0]  reg_target,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [7:0]  opcode,
    output logic [7:0]  immediate,
    output logic        ir_valid,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic        ir_valid_reg, ir_valid_next;
    logic        req_reg, req_next;
    logic [7:0]  addr_reg, addr_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic        halt_block;

`ifdef FETCH_HALT_DETECT_EN
    logic        halted_reg, halted_next;

    assign halt_block = halted_reg;

    // Halt flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) halted_reg <= 1'b0;
        else       halted_reg <= halted_next;
    end
`else
    assign halt_block = 1'b0;
`endif

    // All fetch-unit state registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= 8'h00;
            ir_reg       <= 16'h0000;
            ir_valid_reg <= 1'b0;
            req_reg      <= 1'b0;
            addr_reg     <= 8'h00;
            cnt_reg      <= 4'h0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            req_reg      <= req_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic: request launch and PC updates in IDLE; ack or timeout
    // completion in FETCH.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        req_next      = req_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        err_next      = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
        halted_next   = halted_reg;
`endif
        case (state_reg)
            IDLE: begin
                // The request address is the pre-update pc, so a PC change in
                // the same cycle affects only the following fetch.
                if (load_ir && !halt_block) begin
                    state_next    = FETCH;
                    req_next      = 1'b1;
                    addr_next     = pc_reg;
                    ir_valid_next = 1'b0;
                    cnt_next      = 4'h0;
                end
                if (!halt_block) begin
                    if (load_pc)
                        pc_next = sel_pc ? ir_reg[7:0] : reg_target;
                    else if (inc_pc)
                        pc_next = pc_reg + 8'h01;
                end
            end
            FETCH: begin
                // An ack takes priority over a timeout on the same cycle.
                if (imem_ack) begin
                    state_next    = IDLE;
                    ir_next       = imem_rdata;
                    ir_valid_next = 1'b1;
                    req_next      = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
                    if (imem_rdata[15:12] == 4'b1111)
                        halted_next = 1'b1;
`endif
                end else if (cnt_reg == 4'hF) begin
                    state_next    = IDLE;
                    ir_next       = 16'h0000;
                    ir_valid_next = 1'b1;
                    req_next      = 1'b0;
                    err_next      = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'h1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;
    assign opcode    = ir_reg[15:8];
    assign immediate = ir_reg[7:0];
    assign ir_valid  = ir_valid_reg;
    assign pc        = pc_reg;
    assign busy      = (state_reg == FETCH);
    assign fetch_err = err_reg;
`ifdef FETCH_HALT_DETECT_EN
    assign halted    = halted_reg;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed vectors for fetch_unit, followed by
// hand-written sequences for timeout, ack-at-timeout priority and reset
// during FETCH. Follows FETCH_HALT_DETECT_EN if it is defined for the build.
module tb_fetch_unit;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_ir = 1'b0;
    logic        inc_pc = 1'b0;
    logic        load_pc = 1'b0;
    logic        sel_pc = 1'b0;
    logic [7:0]  reg_target = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [7:0]  opcode;
    logic [7:0]  immediate;
    logic        ir_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_err;
    logic        halted;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .sel_pc(sel_pc), .reg_target(reg_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .opcode(opcode), .immediate(immediate),
        .ir_valid(ir_valid), .pc(pc), .busy(busy), .fetch_err(fetch_err),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ld, inc, ldpc, sel;
        logic [7:0]  tgt;
        logic        ack;
        logic [15:0] rdata;
        logic        req;
        logic [7:0]  addr, opc, imm;
        logic        vld;
        logic [7:0]  pce;
        logic        bsy, err, hlt;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, ld, inc, ldpc, sel, input logic [7:0] tgt,
        input logic ack, input logic [15:0] rdata,
        input logic req, input logic [7:0] addr, opc, imm,
        input logic vld, input logic [7:0] pce, input logic bsy, err, hlt);
        vec_t v;
        v.rst = rst; v.ld = ld; v.inc = inc; v.ldpc = ldpc; v.sel = sel;
        v.tgt = tgt; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.opc = opc; v.imm = imm; v.vld = vld;
        v.pce = pce; v.bsy = bsy; v.err = err; v.hlt = hlt;
        return v;
    endfunction

    // Drive one vector, clock it in, then compare all outputs 1 ns after the edge.
    task automatic apply(input vec_t v, input string tag);
        logic [43:0] act, exp;
        reset = v.rst; load_ir = v.ld; inc_pc = v.inc; load_pc = v.ldpc;
        sel_pc = v.sel; reg_target = v.tgt; imem_ack = v.ack; imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        act = {imem_req, imem_addr, opcode, immediate, ir_valid, pc, busy, fetch_err, halted};
        exp = {v.req, v.addr, v.opc, v.imm, v.vld, v.pce, v.bsy, v.err, v.hlt};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got req=%b addr=%h op=%h imm=%h vld=%b pc=%h busy=%b err=%b halt=%b, want req=%b addr=%h op=%h imm=%h vld=%b pc=%h busy=%b err=%b halt=%b",
                     tag, imem_req, imem_addr, opcode, immediate, ir_valid, pc, busy, fetch_err, halted,
                     v.req, v.addr, v.opc, v.imm, v.vld, v.pce, v.bsy, v.err, v.hlt);
        end else begin
            $display("%s: req=%b addr=%h op=%h imm=%h vld=%b pc=%h busy=%b err=%b halt=%b ok",
                     tag, imem_req, imem_addr, opcode, immediate, ir_valid, pc, busy, fetch_err, halted);
        end
    endtask

    vec_t tbl[15];

    initial begin
        // Reset, basic fetch, PC wrap, PC loads, FETCH-time ignores, HALT word.
        tbl[0]  = mk(1,0,0,0,0,8'h00,0,16'h0000, 0,8'h00,8'h00,8'h00,0,8'h00,0,0,0);
        tbl[1]  = mk(0,1,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h00,8'h00,0,8'h00,1,0,0);
        tbl[2]  = mk(0,0,0,0,0,8'h00,1,16'h4A05, 0,8'h00,8'h4A,8'h05,1,8'h00,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,8'h00,1,16'h1234, 0,8'h00,8'h4A,8'h05,1,8'h00,0,0,0);
        tbl[4]  = mk(0,0,0,1,0,8'hFF,0,16'h0000, 0,8'h00,8'h4A,8'h05,1,8'hFF,0,0,0);
        tbl[5]  = mk(0,0,1,0,0,8'h00,0,16'h0000, 0,8'h00,8'h4A,8'h05,1,8'h00,0,0,0);
        tbl[6]  = mk(0,1,1,0,0,8'h00,0,16'h0000, 1,8'h00,8'h4A,8'h05,0,8'h01,1,0,0);
        tbl[7]  = mk(0,1,1,1,1,8'h00,0,16'h0000, 1,8'h00,8'h4A,8'h05,0,8'h01,1,0,0);
        tbl[8]  = mk(0,0,0,0,0,8'h00,1,16'h203C, 0,8'h00,8'h20,8'h3C,1,8'h01,0,0,0);
        tbl[9]  = mk(0,0,1,1,1,8'h00,0,16'h0000, 0,8'h00,8'h20,8'h3C,1,8'h3C,0,0,0);
        tbl[10] = mk(0,0,1,1,0,8'h91,0,16'h0000, 0,8'h00,8'h20,8'h3C,1,8'h91,0,0,0);
        tbl[11] = mk(0,1,0,0,0,8'h00,0,16'h0000, 1,8'h91,8'h20,8'h3C,0,8'h91,1,0,0);
        tbl[12] = mk(0,0,0,0,0,8'h00,1,16'hF000, 0,8'h91,8'hF0,8'h00,1,8'h91,0,0,H);
        tbl[13] = mk(0,1,1,0,0,8'h00,0,16'h0000, !H,8'h91,8'hF0,8'h00,H,
                     H ? 8'h91 : 8'h92, !H,0,H);
        tbl[14] = mk(0,0,0,0,0,8'h00,1,16'h1111, 0,8'h91,H ? 8'hF0 : 8'h11,
                     H ? 8'h00 : 8'h11,1,H ? 8'h91 : 8'h92,0,0,H);

        for (int i = 0; i < 15; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Timeout: 16 FETCH cycles without ack -> NOP, single-cycle fetch_err.
        apply(mk(1,0,0,0,0,8'h00,0,16'h0000, 0,8'h00,8'h00,8'h00,0,8'h00,0,0,0), "to_reset");
        apply(mk(0,1,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h00,8'h00,0,8'h00,1,0,0), "to_launch");
        for (int i = 0; i < 15; i++)
            apply(mk(0,0,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h00,8'h00,0,8'h00,1,0,0),
                  $sformatf("to_wait%0d", i));
        apply(mk(0,0,0,0,0,8'h00,0,16'h0000, 0,8'h00,8'h00,8'h00,1,8'h00,0,1,0), "to_expire");
        apply(mk(0,0,0,0,0,8'h00,1,16'hBEEF, 0,8'h00,8'h00,8'h00,1,8'h00,0,0,0), "to_late_ack");

        // Ack on the cycle the counter reaches 15 wins over timeout.
        apply(mk(0,1,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h00,8'h00,0,8'h00,1,0,0), "pri_launch");
        for (int i = 0; i < 15; i++)
            apply(mk(0,0,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h00,8'h00,0,8'h00,1,0,0),
                  $sformatf("pri_wait%0d", i));
        apply(mk(0,0,0,0,0,8'h00,1,16'h5A5A, 0,8'h00,8'h5A,8'h5A,1,8'h00,0,0,0), "pri_ack");

        // Reset during FETCH drops the request; a later ack does not load IR.
        apply(mk(0,1,0,0,0,8'h00,0,16'h0000, 1,8'h00,8'h5A,8'h5A,0,8'h00,1,0,0), "rst_launch");
        apply(mk(1,0,0,0,0,8'h00,0,16'h0000, 0,8'h00,8'h00,8'h00,0,8'h00,0,0,0), "rst_mid");
        apply(mk(0,0,0,0,0,8'h00,1,16'hABCD, 0,8'h00,8'h00,8'h00,0,8'h00,0,0,0), "rst_ack");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 load_ir  input  1  controller request to fetch next instruction into IR.
REQ-004 inc_pc  input  1  increment PC by 1.
REQ-005 load_pc  input  1  load PC from source chosen by sel_pc.
REQ-006 sel_pc  input  1  PC source: 0 = reg_target, 1 = immediate.
REQ-007 reg_target  input  8  jump-register value from register file.
REQ-008 imem_req  output  1  memory read request, held until ack.
REQ-009 imem_addr  output  8  read address, registered at request launch.
REQ-010 imem_ack  input  1  memory read data valid this cycle.
REQ-011 imem_rdata  input  16  instruction word: [15:8] opcode, [7:0] immediate.
REQ-012 opcode  output  8  IR[15:8], feeds controller Opcode.
REQ-013 immediate  output  8  IR[7:0], feeds PC mux and accumulator mux.
REQ-014 ir_valid  output  1  IR holds a completed fetch.
REQ-015 pc  output  8  current program counter.
REQ-016 busy  output  1  high while state is FETCH.
REQ-017 fetch_err  output  1  one-cycle pulse on fetch timeout.
REQ-018 halted  output  1  halt latched (see Configuration).

Function
REQ-019 FSM SHALL have two states, IDLE and FETCH; busy = (state == FETCH).
REQ-020 In IDLE with load_ir=1: next cycle state=FETCH, imem_req=1, imem_addr=pc, ir_valid=0, timeout counter=0.
REQ-021 In FETCH: imem_req and imem_addr SHALL stay stable until ack or timeout; load_ir SHALL be ignored.
REQ-022 In FETCH with imem_ack=1: next cycle IR=imem_rdata, ir_valid=1, imem_req=0, state=IDLE; fetch latency = 2 cycles from load_ir when ack is returned on the first request cycle.
REQ-023 Timeout counter SHALL be 4 bits, increment each FETCH cycle without ack; when it reaches 15 with no ack: next cycle IR=16'h0000 (NOP), ir_valid=1, fetch_err=1 for exactly one cycle, imem_req=0, state=IDLE.
REQ-024 Ack arriving on the same cycle the counter reaches 15 SHALL take priority over timeout (no fetch_err).
REQ-025 imem_ack while in IDLE SHALL be ignored.
REQ-026 PC updates SHALL apply only in IDLE; in FETCH inc_pc/load_pc are ignored.
REQ-027 Priority: load_pc over inc_pc; load_pc sets pc = sel_pc ? immediate : reg_target.
REQ-028 inc_pc SHALL wrap 8'hFF to 8'h00.
REQ-029 load_ir and a PC update in the same IDLE cycle: request SHALL use the pre-update pc; PC update SHALL still take effect.

Reset
REQ-030 On reset: state=IDLE, pc=0, IR=0, ir_valid=0, imem_req=0, imem_addr=0, counter=0, fetch_err=0, halted=0.
REQ-031 Reset during FETCH SHALL drop imem_req the next cycle; an ack after reset SHALL not load IR.

Configuration
REQ-032 Macro FETCH_HALT_DETECT_EN: when defined, a completed fetch with imem_rdata[15:12]=4'b1111 SHALL set halted=1 and all further load_ir, inc_pc, load_pc SHALL be ignored until reset.
REQ-033 Without FETCH_HALT_DETECT_EN, halted SHALL be tied 0 and HALT opcodes SHALL be fetched like any other word.

Verification
REQ-034 Reset, load_ir pulse, ack on first request cycle with rdata=16'h4A05 -> opcode=8'h4A, immediate=8'h05, ir_valid=1 two cycles after load_ir, pc=0.
REQ-035 pc=8'hFF, inc_pc=1 in IDLE -> pc=8'h00 next cycle.
REQ-036 IR immediate=8'h3C, load_pc=1, sel_pc=1, inc_pc=1 -> pc=8'h3C; repeat with sel_pc=0, reg_target=8'h91 -> pc=8'h91.
REQ-037 load_ir, no ack for 16 cycles -> fetch_err single-cycle pulse, IR=16'h0000, ir_valid=1, imem_req=0; late ack ignored.
REQ-038 Reset asserted mid-FETCH then ack -> imem_req=0, ir_valid=0, IR=0.
REQ-039 With FETCH_HALT_DETECT_EN, fetch rdata=16'hF000 then load_ir, inc_pc -> halted=1, no new imem_req, pc unchanged; without macro -> halted=0, next fetch proceeds.
